jtframe_pocket_vidrx: RTL and testbench

Receiver for the Analogue Pocket video bus: consumes the `pck_*` signals a core drives towards the Pocket scaler and turns them back into a pixel stream with coordinates plus measured frame geometry. It sits in simulation benches and in the debug path of the Pocket target, so the video output stage can be checked against the original core timing.

---
 rtl/jtframe_pocket_vidrx.sv | 143 ++++++++++++++
 tb/tb_jtframe_pocket_vidrx.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/jtframe_pocket_vidrx.sv
// Analogue Pocket video bus receiver.
// Rebuilds the pixel stream with coordinates from the pck_* signals and
// measures frame geometry: total and active pixels per line, and total and
// active lines per frame. All pck_* inputs are sampled on the falling edge
// of pck_rgb_clk, because the transmitter updates them on the rising edge.
module jtframe_pocket_vidrx #(
    parameter int HW = 12,
    parameter int VW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [23:0]   pck_rgb,
    input  logic          pck_rgb_clk,
    input  logic          pck_de,
    input  logic          pck_skip,
    input  logic          pck_hs,
    input  logic          pck_vs,
    output logic [23:0]   pix_rgb,
    output logic [HW-1:0] pix_x,
    output logic [VW-1:0] pix_y,
    output logic          pix_valid,
    output logic [HW-1:0] htotal,
    output logic [HW-1:0] hactive,
    output logic [VW-1:0] vtotal,
    output logic [VW-1:0] vactive,
    output logic          frame_valid,
    output logic          locked,
    output logic          err
);

    localparam logic [HW-1:0] HMAX = {HW{1'b1}};
    localparam logic [VW-1:0] VMAX = {VW{1'b1}};

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [HW-1:0] inc_h(input logic [HW-1:0] v);
        return (v == HMAX) ? v : v + {{(HW-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [VW-1:0] inc_v(input logic [VW-1:0] v);
        return (v == VMAX) ? v : v + {{(VW-1){1'b0}}, 1'b1};
    endfunction

    logic          rgbclk_l;
    logic [HW-1:0] hcnt_r, acnt_r, htot_r, ref_act_r;
    logic [VW-1:0] vcnt_r, lcnt_r;
    logic          line_act_r, ref_seen_r, err_acc_r, armed_r;

    logic          stb_s, act_s;
    logic [HW-1:0] hcnt_inc_s, acnt_fin_s, htot_fin_s, ref_fin_s;
    logic [VW-1:0] vcnt_fin_s, lcnt_fin_s;
    logic          line_act_fin_s, first_now_s, mism_s, err_fin_s, close_act_s;

    // Values as they stand after this strobe: a de pixel that shares its
    // strobe with hs belongs to the line being closed.
    always_comb begin
        stb_s          = rgbclk_l & ~pck_rgb_clk;
        act_s          = stb_s & ~pck_skip;
        hcnt_inc_s     = inc_h(hcnt_r);
        acnt_fin_s     = pck_de ? inc_h(acnt_r) : acnt_r;
        line_act_fin_s = line_act_r | pck_de;
        close_act_s    = pck_hs & line_act_fin_s;
        vcnt_fin_s     = pck_hs ? inc_v(vcnt_r) : vcnt_r;
        lcnt_fin_s     = close_act_s ? inc_v(lcnt_r) : lcnt_r;
        first_now_s    = close_act_s & ~ref_seen_r;
        ref_fin_s      = first_now_s ? acnt_fin_s : ref_act_r;
        mism_s         = close_act_s & ref_seen_r & (acnt_fin_s != ref_act_r);
        err_fin_s      = err_acc_r | mism_s;
        htot_fin_s     = pck_hs ? hcnt_inc_s : htot_r;
    end

    // Strobe detection, line/frame counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            rgbclk_l    <= 1'b0;
            hcnt_r      <= '0;
            acnt_r      <= '0;
            htot_r      <= '0;
            ref_act_r   <= '0;
            vcnt_r      <= '0;
            lcnt_r      <= '0;
            line_act_r  <= 1'b0;
            ref_seen_r  <= 1'b0;
            err_acc_r   <= 1'b0;
            armed_r     <= 1'b0;
            pix_rgb     <= 24'd0;
            pix_x       <= '0;
            pix_y       <= '0;
            pix_valid   <= 1'b0;
            htotal      <= '0;
            hactive     <= '0;
            vtotal      <= '0;
            vactive     <= '0;
            frame_valid <= 1'b0;
            locked      <= 1'b0;
            err         <= 1'b0;
        end else begin
            rgbclk_l    <= pck_rgb_clk;
            pix_valid   <= 1'b0;
            frame_valid <= 1'b0;
            if (act_s) begin
                if (pck_de) begin
                    pix_rgb   <= pck_rgb;
                    pix_x     <= acnt_r;
                    pix_y     <= lcnt_r;
                    pix_valid <= 1'b1;
                end
                if (pck_hs) begin
                    hcnt_r     <= '0;
                    acnt_r     <= '0;
                    line_act_r <= 1'b0;
                    htot_r     <= hcnt_inc_s;
                end else begin
                    hcnt_r     <= hcnt_inc_s;
                    acnt_r     <= acnt_fin_s;
                    line_act_r <= line_act_fin_s;
                end
                ref_act_r <= ref_fin_s;
                if (pck_vs) begin
                    if (armed_r) begin
                        htotal      <= htot_fin_s;
                        hactive     <= ref_fin_s;
                        vtotal      <= vcnt_fin_s;
                        vactive     <= lcnt_fin_s;
                        err         <= err_fin_s;
                        frame_valid <= 1'b1;
                        locked      <= 1'b1;
                    end
                    armed_r    <= 1'b1;
                    vcnt_r     <= '0;
                    lcnt_r     <= '0;
                    err_acc_r  <= 1'b0;
                    ref_seen_r <= 1'b0;
                end else begin
                    vcnt_r     <= vcnt_fin_s;
                    lcnt_r     <= lcnt_fin_s;
                    err_acc_r  <= err_fin_s;
                    ref_seen_r <= ref_seen_r | first_now_s;
                end
            end
        end
    end

endmodule

// File: tb/tb_jtframe_pocket_vidrx.sv
// Scoreboard bench for jtframe_pocket_vidrx: the stimulus side queues the
// expected pixels and frame reports, a monitor pops them on every strobe.
module tb_jtframe_pocket_vidrx;

    typedef struct packed {
        logic [23:0] rgb;
        logic [11:0] x;
        logic [9:0]  y;
    } pix_t;

    typedef struct packed {
        logic [11:0] ht;
        logic [11:0] ha;
        logic [9:0]  vt;
        logic [9:0]  va;
        logic        e;
    } frm_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] pck_rgb;
    logic        pck_rgb_clk, pck_de, pck_skip, pck_hs, pck_vs;
    logic [23:0] pix_rgb;
    logic [11:0] pix_x, htotal, hactive;
    logic [9:0]  pix_y, vtotal, vactive;
    logic        pix_valid, frame_valid, locked, err;

    pix_t pix_q[$];
    frm_t frm_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   frames_exp = 0;
    int   frames_seen = 0;

    jtframe_pocket_vidrx #(.HW(12), .VW(10)) dut (
        .clk(clk), .rst(rst),
        .pck_rgb(pck_rgb), .pck_rgb_clk(pck_rgb_clk), .pck_de(pck_de),
        .pck_skip(pck_skip), .pck_hs(pck_hs), .pck_vs(pck_vs),
        .pix_rgb(pix_rgb), .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid),
        .htotal(htotal), .hactive(hactive), .vtotal(vtotal), .vactive(vactive),
        .frame_valid(frame_valid), .locked(locked), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every emitted pixel / frame report is matched against the queues
    always @(negedge clk) begin
        if (!rst) begin
            if (pix_valid) begin
                if (pix_q.size() == 0) begin
                    check("pix_unexpected", 64'd1, 64'd0);
                end else begin
                    pix_t p;
                    p = pix_q.pop_front();
                    check("pix_rgb", 64'(pix_rgb), 64'(p.rgb));
                    check("pix_x", 64'(pix_x), 64'(p.x));
                    check("pix_y", 64'(pix_y), 64'(p.y));
                end
            end
            if (frame_valid) begin
                frames_seen++;
                if (frm_q.size() == 0) begin
                    check("frame_unexpected", 64'd1, 64'd0);
                end else begin
                    frm_t f;
                    f = frm_q.pop_front();
                    check("htotal", 64'(htotal), 64'(f.ht));
                    check("hactive", 64'(hactive), 64'(f.ha));
                    check("vtotal", 64'(vtotal), 64'(f.vt));
                    check("vactive", 64'(vactive), 64'(f.va));
                    check("err", 64'(err), 64'(f.e));
                    check("locked_at_frame", 64'(locked), 64'd1);
                end
            end
        end
    end

    // One pixel-clock period; also checks pix_valid timing directly
    task automatic drive_px(input logic [23:0] rgb, input logic de, input logic skip,
                            input logic hs, input logic vs, input int hi, input int lo);
        pck_rgb     = rgb;
        pck_de      = de;
        pck_skip    = skip;
        pck_hs      = hs;
        pck_vs      = vs;
        pck_rgb_clk = 1'b1;
        repeat (hi) @(negedge clk);
        pck_rgb_clk = 1'b0;
        @(negedge clk);
        check("pix_latency", 64'(pix_valid), 64'(de & ~skip));
        @(negedge clk);
        check("pix_once", 64'(pix_valid), 64'd0);
        repeat (lo - 2) @(negedge clk);
    endtask

    // 8x4 frame: 5 active px on lines 0..2 (4 on bad_line), hs on px 7,
    // vs on line 3's hs pixel. npx < 32 sends only a partial frame.
    task automatic send_frame(input int bad_line, input bit skip_mode, input int hi,
                              input int lo, input bit rep, input bit rep_err, input int npx);
        int k;
        k = 0;
        if (rep) begin
            frm_q.push_back({12'd8, 12'd5, 10'd4, 10'd3, rep_err});
            frames_exp++;
        end
        for (int m = 0; m < 4; m++) begin
            for (int n = 0; n < 8; n++) begin
                if (k < npx) begin
                    int  na;
                    logic de;
                    logic [23:0] rgb;
                    na  = (m == bad_line) ? 4 : 5;
                    de  = (m < 3) && (n < na);
                    rgb = {8'(m), 8'(n), 8'hA5};
                    if (skip_mode)
                        drive_px(24'hDEAD00, 1'b1, 1'b1, 1'b1, 1'b1, hi, lo);
                    if (de)
                        pix_q.push_back({rgb, 12'(n), 10'(m)});
                    drive_px(rgb, de, 1'b0, n == 7, (m == 3) && (n == 7), hi, lo);
                end
                k++;
            end
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_pix_valid"}, 64'(pix_valid), 64'd0);
        check({tag, "_pix"}, 64'({pix_rgb, pix_x, pix_y}), 64'd0);
        check({tag, "_geom"}, 64'({htotal, hactive, vtotal, vactive}), 64'd0);
        check({tag, "_flags"}, 64'({frame_valid, locked, err}), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        pck_rgb = 24'd0; pck_rgb_clk = 1'b0; pck_de = 1'b0;
        pck_skip = 1'b0; pck_hs = 1'b0; pck_vs = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // First frame only arms, next two report clean geometry
        send_frame(-1, 1'b0, 3, 3, 1'b0, 1'b0, 32);
        check("locked_after_arm", 64'(locked), 64'd0);
        send_frame(-1, 1'b0, 3, 3, 1'b1, 1'b0, 32);
        check("locked_after_first", 64'(locked), 64'd1);
        send_frame(-1, 1'b0, 3, 3, 1'b1, 1'b0, 32);

        // Short line 1 flags err, next clean frame clears it
        send_frame(1, 1'b0, 3, 3, 1'b1, 1'b1, 32);
        send_frame(-1, 1'b0, 3, 3, 1'b1, 1'b0, 32);

        // Skipped periods interleaved carry garbage and must be ignored
        send_frame(-1, 1'b1, 2, 2, 1'b1, 1'b0, 32);
        send_frame(-1, 1'b1, 2, 2, 1'b1, 1'b0, 32);

        // Reset in the middle of line 1
        send_frame(-1, 1'b0, 3, 3, 1'b0, 1'b0, 11);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_zero("midreset");
        rst = 1'b0;
        @(negedge clk);
        send_frame(-1, 1'b0, 3, 3, 1'b0, 1'b0, 32);
        check("locked_after_rearm", 64'(locked), 64'd0);
        send_frame(-1, 1'b0, 3, 3, 1'b1, 1'b0, 32);

        // Asymmetric 2/3 pixel clock phases
        send_frame(-1, 1'b0, 2, 3, 1'b1, 1'b0, 32);

        repeat (5) @(negedge clk);
        check("pix_queue_empty", 64'(pix_q.size()), 64'd0);
        check("frm_queue_empty", 64'(frm_q.size()), 64'd0);
        check("frame_count", 64'(frames_seen), 64'(frames_exp));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
